// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: per-pixel colour from LFSR noise or column bars, with optional bar scrolling.
// Also derives multi-channel audio noise from the pixel shift register.
module vga_pattern_gen #(
   parameter int COLOR_BITS = 8,
   parameter int CPP_LOG2 = 3,
   parameter int DIV_W = 13,
   parameter int BAR_SHIFT = 7,
   parameter int LFSR_BITS = 16,
   parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 16'hB400,
   parameter logic [LFSR_BITS-1:0] SEED = 16'hACE1,
   parameter int AUDIO_CH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  hsync,
   input  logic                  vsync,
   input  logic [1:0]            mode,
   input  logic                  pause,
   input  logic                  scroll,
   output logic [COLOR_BITS-1:0] color,
   output logic [AUDIO_CH-1:0]   audio
);
   localparam logic [DIV_W-1:0] STEP = DIV_W'(1 << CPP_LOG2);
   localparam logic [DIV_W-1:0] AUD_DIV = DIV_W'((1 << (DIV_W - 1)) - 1);

   logic [DIV_W-1:0]      div_q, div_d, scroll_q, scroll_d;
   logic [LFSR_BITS-1:0]  lfsr_q, lfsr_d;
   logic [COLOR_BITS-1:0] sr_q, sr_d, color_q, color_d, bar;
   logic [AUDIO_CH-1:0]   audio_q, audio_d;
   logic                  vsync_q, vs_rise, pix_stb, aud_stb, noise, bar_mono;
   logic [2:0]            bar_sel;

   assign vs_rise = vsync & ~vsync_q;
   assign noise = lfsr_q[0];
   assign pix_stb = (&div_q[CPP_LOG2-1:0]) & ~hsync;
   assign aud_stb = div_q == AUD_DIV;
   assign bar_mono = 1'((div_q + scroll_q) >> (BAR_SHIFT - 2));
   assign bar_sel = 3'((div_q + scroll_q) >> BAR_SHIFT);

   // Colour bars: each output bit picks one of three column bits, widest bar on the MSBs
   for (genvar i = 0; i < COLOR_BITS; i++) begin : g_bar
      assign bar[i] = bar_sel[(3 * i + 2) / COLOR_BITS];
   end

   always_comb begin
      div_d = hsync ? '0 : div_q + DIV_W'(1);
      lfsr_d = (pause && vsync) ? SEED : (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      scroll_d = (vs_rise && scroll) ? scroll_q + STEP : scroll_q;
      sr_d = mode[1] ? (mode[0] ? bar : {COLOR_BITS{bar_mono}})
                     : (mode[0] ? {sr_q[COLOR_BITS-2:0], noise} : {COLOR_BITS{noise}});
      color_d = pix_stb ? sr_q : color_q;
      audio_d = (aud_stb && !mode[1] && !pause) ? sr_q[AUDIO_CH-1:0] : audio_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q <= '0;
         sr_q <= '0;
         color_q <= '0;
         audio_q <= '0;
         lfsr_q <= SEED;
         scroll_q <= '0;
         vsync_q <= 1'b0;
      end else begin
         div_q <= div_d;
         sr_q <= sr_d;
         color_q <= color_d;
         audio_q <= audio_d;
         lfsr_q <= lfsr_d;
         scroll_q <= scroll_d;
         vsync_q <= vsync;
      end
   end

   assign color = color_q;
   assign audio = audio_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of reset, noise, pause, bars, scroll and audio.
module tb_vga_pattern_gen;
   logic       clk = 1'b0;
   logic       reset_n, hsync, vsync, pause, scroll;
   logic [1:0] mode;
   logic [7:0] color;
   logic [1:0] audio;
   int         checks = 0;
   int         errors = 0;
   int         cnt = 0;
   logic [1:0] aud_exp;

   vga_pattern_gen dut (
      .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .mode(mode),
      .pause(pause), .scroll(scroll), .color(color), .audio(audio)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cnt mirrors the line position the design should be at after each edge
   task automatic tick();
      @(posedge clk);
      #1;
      cnt = (hsync || !reset_n) ? 0 : cnt + 1;
   endtask

   task automatic run_to(input int d);
      while (cnt < d) tick();
   endtask

   task automatic pulse(input logic s);
      scroll = s;
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
   endtask

   function automatic logic [15:0] lfsr_after(input int n);
      logic [15:0] l = 16'hACE1;
      for (int k = 0; k < n; k++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      return l;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; hsync = 1'b1; vsync = 1'b0; mode = 2'b01; pause = 1'b0; scroll = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      hsync = 1'b0;
      repeat (20) tick();
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_color", 32'(color), 32'h00);
      check("rst_audio", 32'(audio), 32'h0);
      check("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
      check("rst_div", 32'(dut.div_q), 32'h0);
      reset_n = 1'b1; hsync = 1'b1; vsync = 1'b1;
      tick();
      check("lfsr_step1", 32'(dut.lfsr_q), 32'hE270);
      repeat (9) tick();
      vsync = 1'b0; hsync = 1'b0;
      run_to(8);
      check("noise_free", 32'(color), 32'h46);
      for (int f = 0; f < 2; f++) begin
         pause = 1'b1; hsync = 1'b1; vsync = 1'b1;
         repeat (10) tick();
         vsync = 1'b0; hsync = 1'b0;
         run_to(8);
         check("pause_px0", 32'(color), 32'hC3);
         check("pause_lfsr", 32'(dut.lfsr_q), 32'hC2C4);
         run_to(16);
         check("pause_px1", 32'(color), 32'h91);
      end
      pause = 1'b0; mode = 2'b10; hsync = 1'b1;
      repeat (10) tick();
      check("div_hsync", 32'(dut.div_q), 32'h0);
      hsync = 1'b0;
      run_to(8);  check("mono_7", 32'(color), 32'h00);
      run_to(32); check("mono_31", 32'(color), 32'h00);
      run_to(40); check("mono_39", 32'(color), 32'hFF);
      run_to(64); check("mono_63", 32'(color), 32'hFF);
      run_to(72); check("mono_71", 32'(color), 32'h00);
      hsync = 1'b1; mode = 2'b11;
      repeat (10) tick();
      hsync = 1'b0;
      run_to(8);   check("cbar_7", 32'(color), 32'h00);
      run_to(128); check("cbar_127", 32'(color), 32'h00);
      run_to(136); check("cbar_135", 32'(color), 32'h03);
      run_to(256); check("cbar_255", 32'(color), 32'h03);
      run_to(264); check("cbar_263", 32'(color), 32'h1C);
      run_to(392); check("cbar_391", 32'(color), 32'h1F);
      run_to(520); check("cbar_519", 32'(color), 32'hE0);
      hsync = 1'b1;
      repeat (10) tick();
      check("hold_hsync", 32'(color), 32'hE0);
      reset_n = 1'b0; mode = 2'b00;
      tick();
      reset_n = 1'b1;
      tick();
      hsync = 1'b0;
      aud_exp = lfsr_after(4095)[0] ? 2'b11 : 2'b00;
      run_to(4095);
      check("aud_before", 32'(audio), 32'h0);
      run_to(4096);
      check("aud_update", 32'(audio), 32'(aud_exp));
      hsync = 1'b1; mode = 2'b10;
      repeat (4) tick();
      hsync = 1'b0;
      run_to(4096);
      check("aud_bars_hold", 32'(audio), 32'(aud_exp));
      hsync = 1'b1;
      repeat (4) pulse(1'b1);
      check("scroll_32", 32'(dut.scroll_q), 32'd32);
      pulse(1'b0);
      check("scroll_hold", 32'(dut.scroll_q), 32'd32);
      hsync = 1'b0;
      run_to(8);
      check("scroll_bar", 32'(color), 32'hFF);
      run_to(4096);
      check("aud_bars_hold2", 32'(audio), 32'(aud_exp));
      hsync = 1'b1; mode = 2'b00; pause = 1'b1;
      repeat (4) tick();
      hsync = 1'b0;
      run_to(4096);
      check("aud_pause_hold", 32'(audio), 32'(aud_exp));
      hsync = 1'b1; pause = 1'b0;
      repeat (1020) pulse(1'b1);
      check("scroll_wrap", 32'(dut.scroll_q), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised successor to the VGA noise generator: produces per-pixel colour from an internal LFSR (mono or colour noise) or from column-derived vertical bars (mono or colour), with optional per-frame horizontal scrolling of the bars. Noise can be frozen frame-to-frame, and a multi-channel audio noise output is derived from the pixel shift register. It sits between the VGA timing generator (hsync/vsync source) and the DAC/pin driver, replacing the fixed 8-bit block and its external noise generator. All internal rates use clock enables; there are no derived clocks.

## Interface
- COLOR_BITS, 8, colour output width (≥3)
- CPP_LOG2, 3, log2 of clocks per pixel (≥1)
- DIV_W, 13, line counter width; the audio strobe rate derives from it
- BAR_SHIFT, 7, column bit selecting the widest colour bar (2 ≤ BAR_SHIFT, BAR_SHIFT+2 < DIV_W)
- LFSR_BITS, 16, LFSR width
- LFSR_TAPS, 16'hB400, Galois feedback mask
- SEED, 16'hACE1, LFSR reset/reload value (nonzero)
- AUDIO_CH, 2, audio channel count (≤ COLOR_BITS)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- hsync  in  1  active-high line sync
- vsync  in  1  active-high frame sync
- mode  in  2  00 mono noise, 01 colour noise, 10 mono bars, 11 colour bars
- pause  in  1  freeze noise and mute audio updates
- scroll  in  1  advance bar offset one pixel per frame
- color  out  COLOR_BITS  pixel colour
- audio  out  AUDIO_CH  audio noise bits

## Operation
- reset_n low at an edge: div=0, sr=0, color=0, audio=0, lfsr=SEED, scroll_off=0, vsync_d=0. This applies mid-line and mid-frame, and reset wins over every other event.
- div (DIV_W bits): 0 while hsync is high; otherwise +1 per clock, wrapping modulo 2^DIV_W.
- vs_rise = vsync & ~vsync_d; vsync_d is registered every clock.
- LFSR (Galois): each clock, lfsr ← (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0). noise_bit = lfsr[0].
  - While pause & vsync: lfsr ← SEED instead, so every frame repeats.
- scroll_off (DIV_W bits): on vs_rise with scroll=1, += 2^CPP_LOG2, wrapping. Otherwise it holds.
- x = div + scroll_off, modulo 2^DIV_W.
- sr update, every clock, by mode:
  - 00: all bits = noise_bit.
  - 01: shift left; sr[0] ← noise_bit.
  - 10: all bits = x[BAR_SHIFT-2].
  - 11: bit i = x[BAR_SHIFT + (3i+2)/COLOR_BITS], integer division. For the defaults: bits 7:5 = x[9], bits 4:2 = x[8], bits 1:0 = x[7].
- pix_stb = (div[CPP_LOG2-1:0] all ones). On pix_stb, color ← sr as it was before that edge. color holds during hsync.
- aud_stb = (div == 2^(DIV_W-1)-1). On aud_stb with mode[1]=0 and pause=0, audio ← sr[AUDIO_CH-1:0]. Otherwise audio holds.
- A mode change affects sr on the next edge and reaches color at the following pix_stb. There is no flush.

## Timing
- Let edge 0 be the first edge with hsync low, where div goes 0→1. pix_stb occurs at div = 7, 15, 23, … (defaults). The new color is visible the cycle after each strobe.
- Pipeline: div(t) → sr(t+1) → color at the next pix_stb. Bar edges are therefore delayed by 1 clock relative to div.
- A vs_rise with pause=1 reloads SEED at the same edge. scroll_off and vsync_d update on that edge too.
- Simultaneous vs_rise and pix_stb: both take effect; color uses the pre-edge sr.
- An audio strobe with default DIV_W occurs once per line, at div=4095, and only on lines longer than 4096 clocks. On shorter lines audio never updates.

## Test plan
- Reset: hold reset_n low 3 clocks mid-line with mode=01 → color=0, audio=0, lfsr=0xACE1 the cycle after release.
- Mono bars: mode=10, scroll=0, hsync falls → color 0x00 after strobes at div 7…31, 0xFF after strobes 39…63, 0x00 again from 71.
- Colour bars: mode=11 → color 0x00 for x<128, 0x03 for 128–255, 0x1C for 256–383, 0x1F for 384–511, 0xE0 from 512.
- Pause: mode=01, pause=1, two frames → identical color sequence per line position. With pause=0 the sequences differ, and audio is unchanged during pause.
- Scroll: scroll=1, 4 vs_rise pulses → scroll_off=32. With mode=10, the first 0xFF comes from the strobe at div=7. Wrap check: after 1024 frames scroll_off=0 (DIV_W=13: 8192/8).
- Audio: mode=00, pause=0, line ≥4097 clocks → at div=4095, audio ← sr[1:0] (0 or 3). With mode=10, audio holds its prior value.
